// File: rtl/gf128_naive.sv
// gf128_naive: schoolbook carry-less multiplier over GF(2)[x].
// 128-bit a times 128-bit b gives a 256-bit unreduced product. Partial products
// are XOR-accumulated, and there is no modular reduction.
// This is the golden baseline that the downstream reduction and Karatsuba
// datapaths are compared against.
// Build option: define GF128_NAIVE_OUTREG_EN to register product/out_valid.
// That build has one cycle of latency and an async active-low reset.
// With the macro undefined, the block is purely combinational.
module gf128_naive (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] a,
  input  logic [127:0] b,
  output logic         out_valid,
  output logic [255:0] product
);

  // Combinational carry-less product of the current operands.
  logic [255:0] product_next;

  // One partial product per bit of b. Each one is a shifted copy of a, masked by b[gi].
  // The running XOR is chained through per-block nets, not one shared
  // array. Each stage therefore depends only on the previous block.
  genvar gi;
  generate
    for (gi = 0; gi < 128; gi++) begin : g_pp
      logic [255:0] pp;
      logic [255:0] sum;
      assign pp = {256{b[gi]}} & ({128'b0, a} << gi);
      if (gi == 0) begin : g_first
        assign sum = pp;
      end else begin : g_rest
        assign sum = g_pp[gi-1].sum ^ pp;
      end
    end
  endgenerate

  assign product_next = g_pp[127].sum;

`ifdef GF128_NAIVE_OUTREG_EN
  logic [255:0] product_reg;
  logic         out_valid_reg;

  // Output register: loads every cycle regardless of in_valid. Async reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_reg   <= 256'h0;
      out_valid_reg <= 1'b0;
    end else begin
      product_reg   <= product_next;
      out_valid_reg <= in_valid;
    end
  end

  assign product   = product_reg;
  assign out_valid = out_valid_reg;
`else
  // Clock and reset have no function in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign product   = product_next;
  assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_gf128_naive.sv
// tb_gf128_naive: directed and random checks of the carry-less multiplier.
// The same bench serves both the combinational and the registered build.
// It follows GF128_NAIVE_OUTREG_EN.
module tb_gf128_naive;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] a;
  logic [127:0] b;
  logic         out_valid;
  logic [255:0] product;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  gf128_naive dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .product   (product)
  );

  // Reference: product[k] = XOR over i+j=k of x[i]&y[j].
  function automatic logic [255:0] model(input logic [127:0] x, input logic [127:0] y);
    logic [255:0] r;
    logic         bk;
    int           lo;
    int           hi;
    r = '0;
    for (int k = 0; k < 255; k++) begin
      bk = 1'b0;
      lo = (k > 127) ? k - 127 : 0;
      hi = (k < 127) ? k : 127;
      for (int i = lo; i <= hi; i++) bk = bk ^ (x[i] & y[k-i]);
      r[k] = bk;
    end
    return r;
  endfunction

  task automatic check_p(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: product=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: out_valid=%b required=%b", tag, obs, exp);
    end
  endtask

  // Apply operands and wait until the result should be visible.
  task automatic drive(input logic [127:0] ta, input logic [127:0] tb, input logic tv);
    a        = ta;
    b        = tb;
    in_valid = tv;
`ifdef GF128_NAIVE_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic step(input string tag, input logic [127:0] ta, input logic [127:0] tb,
                      input logic tv, input logic [255:0] exp);
    drive(ta, tb, tv);
    $display("%s a=%h b=%h v=%b product=%h", tag, ta, tb, tv, product);
    check_p(tag, product, exp);
    check_v(tag, out_valid, tv);
  endtask

  logic [127:0] ones;
  logic [127:0] msb;
  logic [255:0] bit254;
  logic [127:0] ra;
  logic [127:0] rb;

  initial begin
    ones   = {128{1'b1}};
    msb    = 128'h1 << 127;
    bit254 = 256'h1 << 254;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    @(posedge clk);
    #1;
    $display("reset product=%h out_valid=%b", product, out_valid);
    check_p("reset", product, 256'h0);
    check_v("reset", out_valid, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    step("one_x_one",   128'h1, 128'h1, 1'b1, 256'h1);
    step("three_sq",    128'h3, 128'h3, 1'b0, 256'h5);
    step("ones_x_one",  ones,   128'h1, 1'b1, {128'h0, ones});
    step("one_x_ones",  128'h1, ones,   1'b1, {128'h0, ones});
    step("msb_sq",      msb,    msb,    1'b1, bit254);
    n_checks++;
    assert (product[255] === 1'b0) else begin
      n_fails++;
      $error("FAIL msb_bit255: product[255]=%b required=0", product[255]);
    end
    step("one_x_x",     128'h1, 128'h2, 1'b1, 256'h2);
    step("zero_x_ones", 128'h0, ones,   1'b1, 256'h0);
    step("ab_pat",      128'h5, 128'h3, 1'b0, 256'hf);
    step("ba_pat",      128'h3, 128'h5, 1'b1, 256'hf);
    step("ones_sq",     ones,   ones,   1'b1, model(ones, ones));

`ifdef GF128_NAIVE_OUTREG_EN
    // The output must hold the previous result until the next edge.
    a        = 128'h6;
    b        = 128'h7;
    in_valid = 1'b0;
    #1;
    $display("hold a=%h b=%h product=%h", a, b, product);
    check_p("hold_prev", product, model(ones, ones));
    check_v("hold_prev", out_valid, 1'b1);
    step("lat_6x7", 128'h6, 128'h7, 1'b1, 256'h12);

    // Reset in the middle of the stream takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    $display("midrst product=%h out_valid=%b", product, out_valid);
    check_p("midrst_async", product, 256'h0);
    check_v("midrst_async", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_p("midrst_held", product, 256'h0);
    check_v("midrst_held", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 128'h2, 128'h2, 1'b1, 256'h4);
`else
    // Reset and clock must not disturb the combinational result.
    step("pre_rst_tog", 128'h6, 128'h7, 1'b1, 256'h12);
    rst_n = 1'b0;
    #1;
    $display("rst_low product=%h out_valid=%b", product, out_valid);
    check_p("rst_no_effect", product, 256'h12);
    check_v("rst_no_effect", out_valid, 1'b1);
    @(posedge clk);
    #1;
    check_p("clk_no_effect", product, 256'h12);
    rst_n = 1'b1;
    step("post_rst", 128'h2, 128'h2, 1'b1, 256'h4);
`endif

    for (int t = 0; t < 500; t++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      step("rand", ra, rb, t[0], model(ra, rb));
      if (n_fails != 0) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
